sdram_frame_scheduler: RTL
==========================

Name: sdram_frame_scheduler

Overview:
Sequences the full-page SDRAM controller between two requesters: the camera write FIFO (drain to SDRAM) and the VGA read FIFO (refill from SDRAM). It issues one 512-word page command per grant. It owns a triple-buffered frame map so the display never shows a partially written frame. It sits between the FIFO fill-level counters and the controller's rw/rw_en/f_addr/ready handshake.

Parameters:
PAGES_PER_FRAME, 600, full-page bursts per 640x480 frame; frame k base address = k*PAGES_PER_FRAME.
WR_THRESH, 512, a write is requested when wr_fifo_count > WR_THRESH.
RD_THRESH, 250, a read is requested when rd_fifo_count < RD_THRESH.
MAX_WR_RUN, 4, maximum consecutive write grants while a read is pending.

Ports:
clk  in  1  system clock; same domain as the SDRAM controller.
rst  in  1  synchronous reset, active-high.
en  in  1  scheduler enable; low means no new grants are issued.
cam_vsync  in  1  one-cycle pulse; restarts the current write frame at page 0.
wr_fifo_count  in  10  camera FIFO read-side fill level.
rd_fifo_count  in  10  VGA FIFO write-side fill level.
ready  in  1  controller is idle and can accept a command.
rw_en  out  1  one-cycle command strobe.
rw  out  1  1 = read, 0 = write; valid with rw_en.
f_addr  out  15  page address {row, bank}; valid with rw_en.
wr_frame_done  out  1  one-cycle pulse when the last page of a write frame is issued.
rd_frame_swap  out  1  one-cycle pulse when the reader adopts a newer frame.
wr_idx  out  2  current write frame index.
rd_idx  out  2  current read frame index.
busy  out  1  high from grant until the controller returns to ready.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: rw_en=0, rw=0, f_addr=0, pulses=0, busy=0; wr_page=0, rd_page=0, wr_idx=0, rd_idx=2, latest=1, fresh=0, first_done=0, wr_run=0; state=ARB.
- A reset asserted mid-operation aborts BUSY immediately. No further strobe is issued.
- States:
  - ARB: evaluate requests each cycle.
  - ISSUE: drive rw_en=1 for exactly one cycle with registered rw and f_addr.
  - WAIT_LO: wait for ready=0.
  - WAIT_HI: wait for ready=1, then return to ARB.
- Request conditions:
  - wr_req = wr_fifo_count > WR_THRESH.
  - rd_req = rd_fifo_count < RD_THRESH && first_done.
- Grant condition: in ARB with en=1, ready=1, and at least one request. Latency is 1 cycle: a grant decided in cycle N puts rw_en on the outputs in cycle N+1.
- Priority:
  - Write wins unless rd_req && wr_run == MAX_WR_RUN; in that case read wins.
  - wr_run increments on each write grant while rd_req is high.
  - wr_run clears on any read grant or whenever rd_req is low.
- Address generation:
  - Write: f_addr = wr_idx*PAGES_PER_FRAME + wr_page.
  - Read: f_addr = rd_idx*PAGES_PER_FRAME + rd_page. Width is 15 bits; the maximum value is 1799.
- Write frame completion (issue with wr_page == PAGES_PER_FRAME-1):
  - wr_page wraps to 0 and wr_frame_done pulses.
  - latest <= wr_idx, fresh <= 1, first_done <= 1.
  - wr_idx <= 3 - rd_idx - wr_idx, i.e. the free buffer.
- Read frame swap (read issue with rd_page == 0 and fresh == 1):
  - The address uses latest, and rd_idx <= latest, fresh <= 0, rd_frame_swap pulses.
  - If fresh == 0, the reader repeats the same frame.
  - rd_page wraps from PAGES_PER_FRAME-1 to 0.
- Invariants: rd_idx != wr_idx and latest != wr_idx at all times. The bench asserts both.
- cam_vsync:
  - When it arrives in ARB, wr_page <= 0 for the same wr_idx; no wr_frame_done.
  - When it arrives during ISSUE/WAIT_*, it is latched and applied after the in-flight command's page update. The in-flight write still counts, then is discarded by the restart.
- Only one command is issued per cycle, so write completion and read swap can never coincide.
- en=0:
  - Blocks new grants. An in-flight command still completes through WAIT_HI.
  - Pointers are retained.
- WAIT_LO has no timeout. The controller guarantees ready falls within 2 cycles of an accepted strobe.

Decomposition:
- Package sdram_sched_pkg holds:
  - state enum {ARB, ISSUE, WAIT_LO, WAIT_HI}.
  - Frame index typedef (2 bits).
  - Page counter typedef (10 bits).
  - Constant NUM_FRAMES=3.
- Sub-module frame_index_mgr: owns wr_idx, rd_idx, latest, fresh, first_done. Inputs are wr_frame_end and rd_frame_start strobes; outputs are the indices and the swap pulse.

Test Plan:
- Reset: assert rst for 3 cycles. Expect all outputs 0, wr_idx=0, rd_idx=2, and no rw_en for 10 cycles with counts idle (wr=0, rd=1023).
- Single write: wr_fifo_count=513, ready=1 from cycle 0. Expect rw_en=1, rw=0, f_addr=0 in cycle 1, then busy until ready toggles 0 then 1. A second grant gives f_addr=1.
- Fairness: wr_fifo_count=600 and rd_fifo_count=100 held, first_done preloaded, ready cycling. Expect the grant order W,W,W,W,R,W,W,W,W,R.
- Frame wrap: 600 write grants with no reads. The 600th has f_addr=599 and pulses wr_frame_done; wr_idx becomes 1 and the next write has f_addr=600.
- Read gating and swap: rd_fifo_count=100 before any frame completes gives no read. After the first wr_frame_done, expect a read with f_addr=0, rd_frame_swap pulse, and rd_idx=0.
- vsync restart: cam_vsync pulse after 37 writes. The next write has f_addr=wr_idx*600+0, with no wr_frame_done.

Source files
------------

// File: rtl/sdram_frame_scheduler_pkg.sv
// Shared types and helpers for the SDRAM frame scheduler.
// Frame buffers are addressed as idx*pages_per_frame + page.
package sdram_sched_pkg;

  typedef enum logic [1:0] {
    ARB,
    ISSUE,
    WAIT_LO,
    WAIT_HI
  } state_e;

  typedef logic [1:0] fidx_t;
  typedef logic [9:0] page_t;

  localparam int NUM_FRAMES = 3;

  function automatic logic [14:0] page_addr(
    input fidx_t idx,
    input page_t pg,
    input int    ppf
  );
    return 15'(idx) * 15'(ppf) + 15'(pg);
  endfunction

endpackage

// File: rtl/sdram_frame_scheduler_if.sv
// Command handshake between the scheduler and the
// full-page SDRAM controller.
interface sdram_cmd_if;
  logic        ready;
  logic        rw_en;
  logic        rw;
  logic [14:0] f_addr;

  modport master (
    input  ready,
    output rw_en,
    output rw,
    output f_addr
  );

  modport slave (
    output ready,
    input  rw_en,
    input  rw,
    input  f_addr
  );
endinterface

// File: rtl/sdram_frame_scheduler_frame_index_mgr.sv
// Triple-buffer bookkeeping: writer, reader and the
// newest completed frame never alias.
module frame_index_mgr
  import sdram_sched_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_frame_end,
  input  logic  rd_frame_start,
  output fidx_t wr_idx,
  output fidx_t rd_idx,
  output fidx_t latest,
  output logic  fresh,
  output logic  first_done,
  output logic  rd_frame_swap
);

  fidx_t wr_q, wr_d;
  fidx_t rd_q, rd_d;
  fidx_t lat_q, lat_d;
  logic  fresh_q, fresh_d;
  logic  fd_q, fd_d;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    lat_d   = lat_q;
    fresh_d = fresh_q;
    fd_d    = fd_q;
    if (wr_frame_end) begin
      lat_d   = wr_q;
      fresh_d = 1'b1;
      fd_d    = 1'b1;
      // the one buffer neither side is using
      wr_d    = fidx_t'(NUM_FRAMES) - rd_q - wr_q;
    end
    if (rd_frame_start && fresh_q) begin
      rd_d    = lat_q;
      fresh_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 2'd0;
      rd_q    <= 2'd2;
      lat_q   <= 2'd1;
      fresh_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lat_q   <= lat_d;
      fresh_q <= fresh_d;
      fd_q    <= fd_d;
    end
  end

  assign wr_idx        = wr_q;
  assign rd_idx        = rd_q;
  assign latest        = lat_q;
  assign fresh         = fresh_q;
  assign first_done    = fd_q;
  assign rd_frame_swap = rd_frame_start && fresh_q;

endmodule

// File: rtl/sdram_frame_scheduler.sv
// Arbitrates camera drain vs VGA refill into one page
// command per grant on the SDRAM controller handshake.
module sdram_frame_scheduler
  import sdram_sched_pkg::*;
#(
  parameter int PAGES_PER_FRAME = 600,
  parameter int WR_THRESH       = 512,
  parameter int RD_THRESH       = 250,
  parameter int MAX_WR_RUN      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        cam_vsync,
  input  logic [9:0]  wr_fifo_count,
  input  logic [9:0]  rd_fifo_count,
  sdram_cmd_if.master ctrl,
  output logic        wr_frame_done,
  output logic        rd_frame_swap,
  output fidx_t       wr_idx,
  output fidx_t       rd_idx,
  output logic        busy
);

  localparam page_t LAST = page_t'(PAGES_PER_FRAME - 1);

  state_e      state_q, state_d;
  page_t       wr_page_q, wr_page_d;
  page_t       rd_page_q, rd_page_d;
  logic [2:0]  run_q, run_d;
  logic        rw_q, rw_d;
  logic [14:0] addr_q, addr_d;
  logic        end_q, end_d;
  logic        start_q, start_d;
  logic        vs_q, vs_d;

  fidx_t latest;
  logic  fresh, first_done;
  logic  wr_req, rd_req, grant, pick_rd;
  page_t wr_pg;

  assign wr_req  = wr_fifo_count > 10'(WR_THRESH);
  assign rd_req  = (rd_fifo_count < 10'(RD_THRESH)) && first_done;
  assign grant   = (state_q == ARB) && en && ctrl.ready
                 && (wr_req || rd_req);
  assign pick_rd = rd_req
                 && (!wr_req || run_q == 3'(MAX_WR_RUN));
  // a restart seen now or while busy takes effect in ARB
  assign wr_pg   = (cam_vsync || vs_q) ? '0 : wr_page_q;

  always_comb begin
    state_d   = state_q;
    wr_page_d = wr_page_q;
    rd_page_d = rd_page_q;
    run_d     = run_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    end_d     = end_q;
    start_d   = start_q;
    vs_d      = vs_q | cam_vsync;
    unique case (state_q)
      ARB: begin
        vs_d      = 1'b0;
        wr_page_d = wr_pg;
        if (grant) begin
          state_d = ISSUE;
          rw_d    = pick_rd;
          if (pick_rd) begin
            addr_d  = page_addr(
              (rd_page_q == '0 && fresh) ? latest : rd_idx,
              rd_page_q, PAGES_PER_FRAME);
            end_d   = 1'b0;
            start_d = rd_page_q == '0;
            run_d   = '0;
          end else begin
            addr_d  = page_addr(wr_idx, wr_pg, PAGES_PER_FRAME);
            end_d   = wr_pg == LAST;
            start_d = 1'b0;
            if (rd_req) run_d = run_q + 3'd1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_LO;
        if (rw_q)
          rd_page_d = (rd_page_q == LAST) ? '0 : rd_page_q + 10'd1;
        else
          wr_page_d = end_q ? '0 : wr_page_q + 10'd1;
      end
      WAIT_LO: if (!ctrl.ready) state_d = WAIT_HI;
      WAIT_HI: if (ctrl.ready) state_d = ARB;
      default: state_d = ARB;
    endcase
    if (!rd_req) run_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB;
      wr_page_q <= '0;
      rd_page_q <= '0;
      run_q     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      end_q     <= 1'b0;
      start_q   <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_page_q <= wr_page_d;
      rd_page_q <= rd_page_d;
      run_q     <= run_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      end_q     <= end_d;
      start_q   <= start_d;
      vs_q      <= vs_d;
    end
  end

  frame_index_mgr u_idx (
    .clk            (clk),
    .rst            (rst),
    .wr_frame_end   (wr_frame_done),
    .rd_frame_start (state_q == ISSUE && rw_q && start_q),
    .wr_idx         (wr_idx),
    .rd_idx         (rd_idx),
    .latest         (latest),
    .fresh          (fresh),
    .first_done     (first_done),
    .rd_frame_swap  (rd_frame_swap)
  );

  assign ctrl.rw_en    = state_q == ISSUE;
  assign ctrl.rw       = rw_q;
  assign ctrl.f_addr   = addr_q;
  assign wr_frame_done = state_q == ISSUE && !rw_q && end_q;
  assign busy          = state_q != ARB;

endmodule
